inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the single-cycle RISC-V core.
- Holds the architectural PC and requests instructions from instruction memory over a req/ack handshake.
- Registers the returned word and presents it to the decoder/control stage.
- On retirement, computes the next PC from the control stage's `pc_sel` and the ALU/immediate results.
- Detects misaligned targets, halts, and keeps a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, instruction word presented while no valid fetch is held (addi x0,x0,0).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pc_sel`  in  2  next-PC select from control: 00 pc+4, 01 branch, 10 jal, 11 jalr.
- `br_taken`  in  1  branch condition from ALU; used only when `pc_sel`=01.
- `imm`  in  32  sign-extended immediate for the held instruction.
- `alu_res`  in  32  ALU result; jalr target base.
- `retire`  in  1  current held instruction completes this cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `inst`  out  32  held instruction to decoder.
- `inst_valid`  out  1  `inst` is valid and executing.
- `pc`  out  32  PC of held/requested instruction.
- `pc4`  out  32  `pc`+4 (link value for jal/jalr).
- `halt`  out  1  misaligned target detected; core stopped.
- `instret`  out  32  count of retired instructions.

## Operation
- States: IDLE, REQ, EXEC, HALT. Reset enters IDLE.
- **IDLE**: all outputs inactive. Next state is REQ unconditionally.
- **REQ**:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until ack.
  - On `imem_ack`: `inst` <= `imem_rdata`, go to EXEC.
  - Otherwise stay in REQ indefinitely; there is no timeout.
- **EXEC**: `inst_valid`=1 and `imem_req`=0.
  - On `retire`: compute npc, `instret` <= `instret`+1 (mod 2^32).
  - If npc[1:0]==00: `pc` <= npc, `inst` <= `NOP_INST`, go to REQ.
  - Otherwise: `halt` <= 1, `pc` unchanged, go to HALT.
- Next-PC rules (32-bit, carries discarded, wrap at 2^32):
  - 00: pc+4
  - 01: `br_taken` ? pc+imm : pc+4
  - 10: pc+imm
  - 11: {alu_res[31:1],1'b0}
- **HALT**: terminal. `halt`=1, `inst_valid`=0, `imem_req`=0. Only reset exits.
- Ignored inputs:
  - `imem_ack` outside REQ is ignored.
  - `retire` outside EXEC is ignored and does not increment `instret`.
- Combinational outputs: `pc4` is always `pc`+4. `imem_addr` is always `pc`.

## Timing
- Reset (`rst_n` low at an edge) sets:
  - state=IDLE, `pc`=`RESET_PC`, `inst`=`NOP_INST`
  - `inst_valid`=0, `imem_req`=0, `halt`=0, `instret`=0
- Reset mid-REQ or mid-EXEC abandons the operation. `imem_req` is low in the cycle after the reset edge.
- First request: `imem_req` rises in the second cycle after `rst_n` is sampled high (IDLE lasts one cycle).
- Ack in cycle N of REQ gives `inst_valid`=1 in cycle N+1.
- Zero-wait memory: minimum 2 cycles per instruction (REQ, EXEC).
- `retire` in EXEC cycle M:
  - `imem_req`=1 with the new `pc` in cycle M+1.
  - `instret` is updated in M+1.
- Control inputs (`pc_sel`, `br_taken`, `imm`, `alu_res`) are sampled only in the EXEC cycle where `retire`=1.
- `rst_n` low has priority over all other events in the same cycle.

## Test plan
- **Reset and first fetch**:
  - Stimulus: `RESET_PC`=0, release reset, ack after 3 wait cycles with 32'h00500093.
  - Required response: `imem_addr`=0 throughout REQ; `inst_valid` rises the cycle after ack with `inst`=32'h00500093; `pc4`=4.
- **Sequential retire**: 4 retires with `pc_sel`=00 and zero-wait ack. `pc` steps 0,4,8,12,16; `instret`=4; 2 cycles per instruction.
- **Branch**: `pc`=0x100, `pc_sel`=01, `imm`=-8.
  - `br_taken`=1: next `imem_addr`=0xF8.
  - `br_taken`=0: next `imem_addr`=0x104.
- **Jumps**:
  - jal with `pc`=0x20, `imm`=0x40: next `imem_addr`=0x60.
  - jalr with `alu_res`=0x1235: next `imem_addr`=0x1234.
- **Misalignment**: jal from `pc`=0x10 with `imm`=0x6.
  - Required response: `halt`=1, `inst_valid`=0, `imem_req` stays 0 for 20 cycles, `pc`=0x10, `instret` incremented once.
  - Then assert reset: `halt`=0 and `pc`=`RESET_PC`.
- **Boundaries**:
  - Reset asserted in the same cycle as `imem_ack`: `inst`=`NOP_INST`.
  - `pc`=0xFFFFFFFC with `pc_sel`=00: wraps to 0.
  - `retire` pulsed during REQ: no `instret` change.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the held word to decode and computes the next PC on retirement.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_sel,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_res,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        halt,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] npc;

  // Next-PC candidates; jalr clears bit 0 of the ALU target.
  always_comb begin
    npc = pc_q + 32'd4;
    unique case (pc_sel)
      2'b00: npc = pc_q + 32'd4;
      2'b01: npc = br_taken ? (pc_q + imm) : (pc_q + 32'd4);
      2'b10: npc = pc_q + imm;
      2'b11: npc = alu_res & 32'hFFFF_FFFE;
      default: npc = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (retire) begin
          instret_d = instret_q + 32'd1;
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            inst_d  = NOP_INST;
            state_d = S_REQ;
          end else begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req   = (state_q == S_REQ);
  assign inst_valid = (state_q == S_EXEC);
  assign halt       = (state_q == S_HALT);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc4        = pc_q + 32'd4;
  assign inst       = inst_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch with hand-computed expected values.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] alu_res;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        halt;
  logic [31:0] instret;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_instret = '0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .br_taken(br_taken),
    .imm(imm), .alu_res(alu_res), .retire(retire),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc4(pc4), .halt(halt), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Held word arrives with zero wait; decode sees it the next cycle.
  task automatic do_ack(input string tag, input logic [31:0] word, input logic [31:0] exp_pc);
    expect_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    expect_eq({tag, "_addr"}, imem_addr, exp_pc);
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    expect_eq({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    expect_eq({tag, "_inst"}, inst, word);
    expect_eq({tag, "_reqlow"}, {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_retire(input string tag, input logic [1:0] sel, input logic br,
                           input logic [31:0] im, input logic [31:0] alu,
                           input logic [31:0] exp_pc);
    pc_sel = sel;
    br_taken = br;
    imm = im;
    alu_res = alu;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    pc_sel = 2'b00;
    br_taken = 1'b0;
    imm = 32'hA5A5_A5A5;
    alu_res = 32'h5A5A_5A5B;
    exp_instret++;
    expect_eq({tag, "_instret"}, instret, exp_instret);
    expect_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    expect_eq({tag, "_addr"}, imem_addr, exp_pc);
    expect_eq({tag, "_nop"}, inst, NOP);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_sel = 2'b00;
    br_taken = 1'b0;
    imm = '0;
    alu_res = '0;
    retire = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    tick();
    tick();
    expect_eq("rst_pc", pc, 32'h0);
    expect_eq("rst_inst", inst, NOP);
    expect_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    expect_eq("rst_req", {31'd0, imem_req}, 32'd0);
    expect_eq("rst_halt", {31'd0, halt}, 32'd0);
    expect_eq("rst_instret", instret, 32'd0);

    // IDLE for one cycle, then request.
    rst_n = 1'b1;
    expect_eq("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_eq("wait_req", {31'd0, imem_req}, 32'd1);
      expect_eq("wait_addr", imem_addr, 32'h0);
      expect_eq("wait_valid", {31'd0, inst_valid}, 32'd0);
      // retire and ack-less cycles in REQ must not count
      retire = (i == 1);
      tick();
      retire = 1'b0;
      expect_eq("req_retire_instret", instret, 32'd0);
    end
    do_ack("first", 32'h0050_0093, 32'h0);
    expect_eq("first_pc4", pc4, 32'h4);

    // ack outside REQ is ignored
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    expect_eq("exec_ack_ignored", inst, 32'h0050_0093);
    expect_eq("exec_still_valid", {31'd0, inst_valid}, 32'd1);

    do_retire("seq1", 2'b00, 1'b0, 32'h0, 32'h0, 32'h4);
    do_ack("seq1", 32'h0000_1111, 32'h4);
    do_retire("seq2", 2'b00, 1'b0, 32'h0, 32'h0, 32'h8);
    do_ack("seq2", 32'h0000_2222, 32'h8);
    do_retire("seq3", 2'b00, 1'b1, 32'h40, 32'h0, 32'hC);
    do_ack("seq3", 32'h0000_3333, 32'hC);
    do_retire("seq4", 2'b00, 1'b0, 32'h0, 32'h0, 32'h10);
    expect_eq("seq_instret4", instret, 32'd4);
    do_ack("seq4", 32'h0000_4444, 32'h10);

    do_retire("jal_to20", 2'b10, 1'b0, 32'h10, 32'h0, 32'h20);
    do_ack("j20", 32'h0400_006F, 32'h20);
    do_retire("jal", 2'b10, 1'b0, 32'h40, 32'h0, 32'h60);
    do_ack("j60", 32'h0000_0067, 32'h60);
    do_retire("jalr", 2'b11, 1'b0, 32'h0, 32'h1235, 32'h1234);
    do_ack("j1234", 32'h0000_0067, 32'h1234);
    do_retire("jalr_to100", 2'b11, 1'b0, 32'h0, 32'h100, 32'h100);
    do_ack("b100a", 32'hFE00_0CE3, 32'h100);
    do_retire("br_taken", 2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'hF8);
    do_ack("bF8", 32'h0000_0067, 32'hF8);
    do_retire("jalr_to100b", 2'b11, 1'b0, 32'h0, 32'h101, 32'h100);
    do_ack("b100b", 32'hFE00_0CE3, 32'h100);
    do_retire("br_not", 2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h104);
    do_ack("b104", 32'h0000_0067, 32'h104);

    do_retire("jalr_top", 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    do_ack("top", 32'h0000_0013, 32'hFFFF_FFFC);
    expect_eq("top_pc4", pc4, 32'h0);
    do_retire("wrap", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    do_ack("wrap", 32'h0000_0067, 32'h0);

    do_retire("jalr_to10", 2'b11, 1'b0, 32'h0, 32'h10, 32'h10);
    do_ack("m10", 32'h0060_006F, 32'h10);
    pc_sel = 2'b10;
    imm = 32'h6;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    exp_instret++;
    expect_eq("mis_halt", {31'd0, halt}, 32'd1);
    expect_eq("mis_valid", {31'd0, inst_valid}, 32'd0);
    expect_eq("mis_pc", pc, 32'h10);
    expect_eq("mis_instret", instret, exp_instret);
    for (int i = 0; i < 20; i++) begin
      retire = 1'b1;
      imem_ack = 1'b1;
      tick();
      expect_eq("halt_req", {31'd0, imem_req}, 32'd0);
      expect_eq("halt_hold", {31'd0, halt}, 32'd1);
    end
    retire = 1'b0;
    imem_ack = 1'b0;
    expect_eq("halt_instret", instret, exp_instret);
    expect_eq("halt_pc", pc, 32'h10);

    rst_n = 1'b0;
    tick();
    expect_eq("hrst_halt", {31'd0, halt}, 32'd0);
    expect_eq("hrst_pc", pc, 32'h0);
    expect_eq("hrst_instret", instret, 32'd0);
    expect_eq("hrst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    expect_eq("rereq", {31'd0, imem_req}, 32'd1);

    // Reset wins over an ack arriving in the same cycle.
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    rst_n = 1'b1;
    expect_eq("rstack_inst", inst, NOP);
    expect_eq("rstack_valid", {31'd0, inst_valid}, 32'd0);
    expect_eq("rstack_req", {31'd0, imem_req}, 32'd0);
    tick();
    expect_eq("rstack_reqback", {31'd0, imem_req}, 32'd1);
    expect_eq("rstack_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
